ctrl_ramarb: RTL and testbench

//  Arbitrates the single data-RAM port between two requesters. One is the convolution sequencer's

---
 rtl/ctrl_ramarb_pkg.sv | 6 +
 rtl/ctrl_wrptr.sv | 30 +++
 rtl/ctrl_ramarb.sv | 105 ++++++++++
 tb/tb_ctrl_ramarb.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_ramarb_pkg.sv
// Shared arbiter state encodings for the controller's RAM-port blocks.
package ctrl_ramarb_pkg;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_RD   = 2'd1;
  localparam logic [1:0] ARB_WR   = 2'd2;
endpackage

// File: rtl/ctrl_wrptr.sv
// Circular write pointer over [base..limit]; load beats advance, never wraps arithmetically.
module ctrl_wrptr #(
  parameter int DATA_ADDR_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       load_i,
  input  logic                       adv_i,
  input  logic [DATA_ADDR_WIDTH-1:0] base_i,
  input  logic [DATA_ADDR_WIDTH-1:0] limit_i,
  output logic [DATA_ADDR_WIDTH-1:0] ptr_o
);
  logic [DATA_ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i)                ptr_d = base_i;
    else if (adv_i) begin
      if (ptr_q >= limit_i)    ptr_d = base_i;
      else                     ptr_d = ptr_q + DATA_ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/ctrl_ramarb.sv
// Data-RAM port arbiter: sequencer reads win, a pending sample is forced through after
// MAX_WAIT lost cycles. Decisions are registered, so the RAM sees them one cycle later.
module ctrl_ramarb
  import ctrl_ramarb_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int MAX_WAIT        = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       s_valid_i,
  input  logic [SAMPLE_WIDTH-1:0]    s_data_i,
  output logic                       s_ready_o,
  input  logic                       c_req_i,
  input  logic [DATA_ADDR_WIDTH-1:0] c_addr_i,
  output logic                       c_gnt_o,
  input  logic [DATA_ADDR_WIDTH-1:0] wr_base_i,
  input  logic [DATA_ADDR_WIDTH-1:0] wr_limit_i,
  input  logic                       wr_load_i,
  output logic [DATA_ADDR_WIDTH-1:0] wr_ptr_o,
  output logic                       new_smp_o,
  output logic                       ram_en_o,
  output logic                       ram_wr_o,
  output logic [DATA_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [SAMPLE_WIDTH-1:0]    ram_wdata_o
);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [1:0]                 state_q, state_d;
  logic                       buf_full_q, buf_full_d;
  logic [SAMPLE_WIDTH-1:0]    buf_q;
  logic [WW-1:0]              wait_cnt_q, wait_cnt_d;
  logic [DATA_ADDR_WIDTH-1:0] ram_addr_q;
  logic [SAMPLE_WIDTH-1:0]    ram_wdata_q;
  logic                       accept, starved, do_wr;

  assign s_ready_o = en_i & ~buf_full_q;
  assign accept    = s_valid_i & s_ready_o;
  assign starved   = buf_full_q && (wait_cnt_q == WW'(MAX_WAIT));

  always_comb begin
    state_d = ARB_IDLE;
    if (en_i) begin
      if (c_req_i && !starved) state_d = ARB_RD;
      else if (buf_full_q)     state_d = ARB_WR;
    end
  end

  assign do_wr = (state_d == ARB_WR);

  // accept and write are mutually exclusive: accept needs an empty buffer, write a full one
  always_comb begin
    buf_full_d = buf_full_q;
    if (do_wr)       buf_full_d = 1'b0;
    else if (accept) buf_full_d = 1'b1;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (do_wr)
      wait_cnt_d = '0;
    else if (en_i && buf_full_q && wait_cnt_q != WW'(MAX_WAIT))
      wait_cnt_d = wait_cnt_q + WW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      buf_full_q  <= 1'b0;
      buf_q       <= '0;
      wait_cnt_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) buf_q <= s_data_i;
      if (state_d == ARB_RD) ram_addr_q <= c_addr_i;
      if (do_wr) begin
        ram_addr_q  <= wr_ptr_o;
        ram_wdata_q <= buf_q;
      end
    end
  end

  ctrl_wrptr #(.DATA_ADDR_WIDTH(DATA_ADDR_WIDTH)) u_wrptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (wr_load_i),
    .adv_i   (do_wr),
    .base_i  (wr_base_i),
    .limit_i (wr_limit_i),
    .ptr_o   (wr_ptr_o)
  );

  assign ram_en_o    = (state_q != ARB_IDLE);
  assign ram_wr_o    = (state_q == ARB_WR);
  assign new_smp_o   = (state_q == ARB_WR);
  assign c_gnt_o     = (state_q == ARB_RD);
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
endmodule

// File: tb/tb_ctrl_ramarb.sv
// Directed bench for ctrl_ramarb: vector table for the sample path, hand sequences for corners.
module tb_ctrl_ramarb;
  logic        clk = 1'b0;
  logic        rst, en, s_valid, s_ready, c_req, c_gnt, wr_load, new_smp;
  logic        ram_en, ram_wr;
  logic [15:0] s_data, ram_wdata;
  logic [3:0]  c_addr, wr_base, wr_limit, wr_ptr, ram_addr;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  ctrl_ramarb dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .c_req_i(c_req), .c_addr_i(c_addr), .c_gnt_o(c_gnt),
    .wr_base_i(wr_base), .wr_limit_i(wr_limit), .wr_load_i(wr_load), .wr_ptr_o(wr_ptr),
    .new_smp_o(new_smp), .ram_en_o(ram_en), .ram_wr_o(ram_wr),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata)
  );

  typedef struct {
    logic        en, sv;
    logic [15:0] sd;
    logic        ld;
    logic [3:0]  base, lim;
    logic        xrdy, xen, xwr, xgnt;
    logic [3:0]  xaddr;
    logic [15:0] xwd;
    logic [3:0]  xptr;
  } vec_t;

  function automatic vec_t mk(logic e, logic v, logic [15:0] d, logic l, logic [3:0] b, logic [3:0] m,
                              logic rdy, logic ren, logic rwr, logic g, logic [3:0] a,
                              logic [15:0] w, logic [3:0] p);
    vec_t t;
    t.en = e; t.sv = v; t.sd = d; t.ld = l; t.base = b; t.lim = m;
    t.xrdy = rdy; t.xen = ren; t.xwr = rwr; t.xgnt = g; t.xaddr = a; t.xwd = w; t.xptr = p;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  vec_t tv[16];
  logic exp_gnt[11];

  initial begin
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0; c_req = 1'b0; c_addr = '0;
    wr_base = '0; wr_limit = '0; wr_load = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ram_en", ram_en, 0);   chk("rst ram_wr", ram_wr, 0);
    chk("rst c_gnt", c_gnt, 0);     chk("rst new_smp", new_smp, 0);
    chk("rst wr_ptr", wr_ptr, 0);   chk("rst s_ready", s_ready, 0);
    chk("rst ram_addr", ram_addr, 0); chk("rst ram_wdata", ram_wdata, 0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("en0 s_ready", s_ready, 0);
    tick();

    // single sample (base 2, limit 5), then four samples wrapping over base 2 limit 3,
    // with junk data offered while the buffer is full
    tv[0]  = mk(1,0,16'h0000,1,2,5, 1,0,0,0, 0,16'h0000,0);
    tv[1]  = mk(1,1,16'h1234,0,2,5, 1,0,0,0, 0,16'h0000,2);
    tv[2]  = mk(1,0,16'h0000,0,2,5, 0,0,0,0, 0,16'h0000,2);
    tv[3]  = mk(1,0,16'h0000,0,2,5, 1,1,1,0, 2,16'h1234,3);
    tv[4]  = mk(1,0,16'h0000,0,2,5, 1,0,0,0, 0,16'h0000,3);
    tv[5]  = mk(1,0,16'h0000,1,2,3, 1,0,0,0, 0,16'h0000,3);
    tv[6]  = mk(1,1,16'h00A1,0,2,3, 1,0,0,0, 0,16'h0000,2);
    tv[7]  = mk(1,1,16'hDEAD,0,2,3, 0,0,0,0, 0,16'h0000,2);
    tv[8]  = mk(1,1,16'h00A2,0,2,3, 1,1,1,0, 2,16'h00A1,3);
    tv[9]  = mk(1,1,16'hBEEF,0,2,3, 0,0,0,0, 0,16'h0000,3);
    tv[10] = mk(1,1,16'h00A3,0,2,3, 1,1,1,0, 3,16'h00A2,2);
    tv[11] = mk(1,1,16'hCAFE,0,2,3, 0,0,0,0, 0,16'h0000,2);
    tv[12] = mk(1,1,16'h00A4,0,2,3, 1,1,1,0, 2,16'h00A3,3);
    tv[13] = mk(1,0,16'h0000,0,2,3, 0,0,0,0, 0,16'h0000,3);
    tv[14] = mk(1,0,16'h0000,0,2,3, 1,1,1,0, 3,16'h00A4,2);
    tv[15] = mk(1,0,16'h0000,0,2,3, 1,0,0,0, 0,16'h0000,2);

    for (int i = 0; i < 16; i++) begin
      en = tv[i].en; s_valid = tv[i].sv; s_data = tv[i].sd; wr_load = tv[i].ld;
      wr_base = tv[i].base; wr_limit = tv[i].lim;
      @(negedge clk);
      chk($sformatf("v%0d s_ready", i), s_ready, tv[i].xrdy);
      chk($sformatf("v%0d ram_en", i), ram_en, tv[i].xen);
      chk($sformatf("v%0d ram_wr", i), ram_wr, tv[i].xwr);
      chk($sformatf("v%0d new_smp", i), new_smp, tv[i].xwr);
      chk($sformatf("v%0d c_gnt", i), c_gnt, tv[i].xgnt);
      chk($sformatf("v%0d wr_ptr", i), wr_ptr, tv[i].xptr);
      if (tv[i].xwr) begin
        chk($sformatf("v%0d ram_addr", i), ram_addr, tv[i].xaddr);
        chk($sformatf("v%0d ram_wdata", i), ram_wdata, tv[i].xwd);
      end
      tick();
    end
    s_valid = 1'b0; wr_load = 1'b0;

    // starvation: reads win three times, then the write is forced, and the counter restarts
    exp_gnt = '{1,1,1,1,0,1,1,1,1,0,1};
    c_req = 1'b1; c_addr = 4'd7;
    for (int i = 0; i < 12; i++) begin
      s_valid = (i == 0 || i == 5);
      s_data  = (i == 0) ? 16'h5555 : 16'h6666;
      if (i > 0) begin
        @(negedge clk);
        chk($sformatf("starve c%0d c_gnt", i), c_gnt, exp_gnt[i-1]);
        chk($sformatf("starve c%0d ram_en", i), ram_en, 1);
        if (exp_gnt[i-1])
          chk($sformatf("starve c%0d rd addr", i), ram_addr, 7);
        else begin
          chk($sformatf("starve c%0d new_smp", i), new_smp, 1);
          chk($sformatf("starve c%0d wr addr", i), ram_addr, (i == 5) ? 2 : 3);
          chk($sformatf("starve c%0d wdata", i), ram_wdata, (i == 5) ? 16'h5555 : 16'h6666);
        end
      end
      tick();
    end
    s_valid = 1'b0; c_req = 1'b0;
    @(negedge clk);
    chk("starve end wr_ptr", wr_ptr, 2);
    tick();

    // en dropped with a sample pending, then restored
    en = 1'b1; c_req = 1'b1; c_addr = 4'd9; s_valid = 1'b1; s_data = 16'h7777;
    tick();
    en = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("en0 read in flight", ram_en, 1);
    chk("en0 s_ready", s_ready, 0);
    tick();
    @(negedge clk);
    chk("en0 ram_en dropped", ram_en, 0);
    chk("en0 c_gnt", c_gnt, 0);
    tick();
    @(negedge clk);
    chk("en0 held ram_en", ram_en, 0);
    chk("en0 held wr_ptr", wr_ptr, 2);
    tick();
    en = 1'b1; c_req = 1'b0;
    tick();
    @(negedge clk);
    chk("en1 ram_wr", ram_wr, 1);
    chk("en1 new_smp", new_smp, 1);
    chk("en1 ram_addr", ram_addr, 2);
    chk("en1 ram_wdata", ram_wdata, 16'h7777);
    tick();

    // reset in the middle of a write cycle
    s_valid = 1'b1; s_data = 16'h8888;
    tick();
    s_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("pre-rst ram_wr", ram_wr, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst ram_en", ram_en, 0);
    chk("midrst ram_wr", ram_wr, 0);
    chk("midrst new_smp", new_smp, 0);
    chk("midrst c_gnt", c_gnt, 0);
    chk("midrst wr_ptr", wr_ptr, 0);
    chk("midrst ram_addr", ram_addr, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d new_smp", i), new_smp, 0);
      chk($sformatf("postrst%0d ram_en", i), ram_en, 0);
      chk($sformatf("postrst%0d wr_ptr", i), wr_ptr, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
